prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Byte-stream boot loader driving the datapath's TB_LOAD_PROGRAM_* / TB_LOAD_DATA_* write ports.
//  Takes framed bytes from a host link (UART RX, JTAG, or bench) and assembles them into 32-bit words.
//  Issues one write pulse per word into instruction or data memory, then raises START for the core.
//  Sits outside DataPath; it is the initiator side of the memory-load interface.
// PARAMETERS
//  ADDR_W   10    word-address width of both memories
//  DATA_W   32    word width; fixed at 32, byte assembly assumes 4 bytes
//  MAX_WORDS 1024 largest accepted word count per frame (must be <= 2**ADDR_W)
// PORTS
//  CLK            in   1       core clock
//  RSTn           in   1       asynchronous active-low reset
//  EN             in   1       global enable; when low, FSM, counters and handshake freeze
//  IN_VALID       in   1       host byte valid
//  IN_DATA        in   8       host byte
//  IN_READY       out  1       loader accepts byte this cycle
//  PROG_CTRL      out  1       one-cycle write strobe to instruction memory (TB_LOAD_PROGRAM_CTRL)
//  PROG_ADDR      out  ADDR_W  instruction-memory word address
//  PROG_DATA      out  DATA_W  instruction word
//  DATA_CTRL      out  1       one-cycle write strobe to data memory (TB_LOAD_DATA_CTRL)
//  DATA_ADDR      out  ADDR_W  data-memory word address
//  DATA_DATA      out  DATA_W  data word
//  START          out  1       core start; sticky high after GO frame until reset
//  BUSY           out  1       high in any state other than IDLE
//  ERR            out  1       sticky error flag; cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, word/byte counters 0, IN_READY=0 for the cycle RSTn deasserts, then 1.
//  Handshake: byte transfers when IN_VALID & IN_READY at posedge CLK. IN_READY=1 in IDLE/CNT_LO/CNT_HI/PAYLOAD/CHECK;
//   0 in WRITE and DONE.
//  Frame: TAG byte, CNT_LO, CNT_HI (count N = {CNT_HI,CNT_LO}, 16 bit), then 4*N payload bytes little-endian,
//   then optional checksum byte. TAG 0x50 'P' -> program memory, 0x44 'D' -> data memory, 0x47 'G' -> go.
//  States: IDLE -(TAG P/D)-> CNT_LO -> CNT_HI -> PAYLOAD <-> WRITE -> (CHECK) -> IDLE; IDLE -(TAG G)-> DONE.
//  PAYLOAD: byte k of word lands in bits [8k+7:8k]; after 4th byte go to WRITE.
//  WRITE (1 cycle): selected CTRL=1 with ADDR=word index, DATA=assembled word; other CTRL stays 0.
//   Word index starts at 0 each frame, +1 per word; then PAYLOAD if words remain, else CHECK/IDLE.
//  CTRL strobes exactly one cycle per word; ADDR/DATA hold last written value between strobes.
//  N=0: CNT_HI goes straight to CHECK (or IDLE); no writes.
//  N>MAX_WORDS: ERR=1, return to IDLE at CNT_HI, no writes; remaining host bytes parsed as new TAGs.
//  Unknown TAG: ERR=1, byte dropped, stay IDLE.
//  DONE: START=1, BUSY=1, IN_READY=0, all CTRL=0; left only by reset.
//  EN=0: state, counters, partial word, outputs held; CTRL forced 0; IN_READY=0; resumes unchanged.
//  Reset mid-frame: partial word discarded, outputs cleared asynchronously; memories keep written words.
//  START may be sampled at posedge after the G byte is accepted (1-cycle latency from handshake).
// CONFIGURATION
//  PROG_LOADER_CHECKSUM_EN defined: after payload, CHECK state accepts one byte; expected value is XOR
//   of all 4*N payload bytes (0x00 when N=0). Mismatch -> ERR=1. Writes are not rolled back. Then IDLE.
//  Undefined: no CHECK state, no checksum byte; frame ends after last WRITE (or CNT_HI when N=0).
// TESTING
//  P frame N=2 words 0x00000013,0x00500093 -> PROG_CTRL pulses at ADDR 0,1 with those words; DATA_CTRL stays 0.
//  D frame N=1 bytes EF BE AD DE -> DATA_CTRL one pulse ADDR 0 DATA 0xDEADBEEF; then G -> START=1 next cycle.
//  TAG 0x7A, then P frame N=1 -> ERR=1, P frame still writes ADDR 0 correctly.
//  P frame N=1025 -> ERR=1, no PROG_CTRL pulse, BUSY=0 after CNT_HI.
//  IN_VALID toggling randomly + EN low 3 cycles mid-word -> same writes as clean stream, no lost/duplicate bytes.
//  With PROG_LOADER_CHECKSUM_EN: P N=1 bytes 01 02 03 04 + 0x04 -> ERR=0; + 0x05 -> ERR=1, word still written.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: byte-stream boot loader that assembles 32-bit words and writes them into program/data memory.
// Optional trailing XOR checksum byte per frame when PROG_LOADER_CHECKSUM_EN is defined.
module prog_loader #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int MAX_WORDS = 1024
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              EN,
    input  logic              IN_VALID,
    input  logic [7:0]        IN_DATA,
    output logic              IN_READY,
    output logic              PROG_CTRL,
    output logic [ADDR_W-1:0] PROG_ADDR,
    output logic [DATA_W-1:0] PROG_DATA,
    output logic              DATA_CTRL,
    output logic [ADDR_W-1:0] DATA_ADDR,
    output logic [DATA_W-1:0] DATA_DATA,
    output logic              START,
    output logic              BUSY,
    output logic              ERR
);
    typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, PAYLOAD, WRITE, CHECK, DONE} state_t;
    localparam logic [7:0] TAG_P = 8'h50;
    localparam logic [7:0] TAG_D = 8'h44;
    localparam logic [7:0] TAG_G = 8'h47;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t END_ST = CHECK;
`else
    localparam state_t END_ST = IDLE;
`endif
    state_t              state_q, state_d;
    logic                is_prog_q, is_prog_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [15:0]         widx_q, widx_d;
    logic [1:0]          byte_q, byte_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic                err_q, err_d;
    logic                rdy_q;
    logic [ADDR_W-1:0]   prog_addr_q, prog_addr_d, data_addr_q, data_addr_d;
    logic [DATA_W-1:0]   prog_data_q, prog_data_d, data_data_q, data_data_d;
    logic [15:0]         n;
    logic                acc;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]          chk_q, chk_d;
`endif

    assign IN_READY  = rdy_q & EN & (state_q != WRITE) & (state_q != DONE);
    assign PROG_CTRL = EN & (state_q == WRITE) & is_prog_q;
    assign DATA_CTRL = EN & (state_q == WRITE) & ~is_prog_q;
    assign PROG_ADDR = prog_addr_q;
    assign PROG_DATA = prog_data_q;
    assign DATA_ADDR = data_addr_q;
    assign DATA_DATA = data_data_q;
    assign START     = state_q == DONE;
    assign BUSY      = state_q != IDLE;
    assign ERR       = err_q;
    assign acc       = IN_VALID & IN_READY;
    assign n         = {IN_DATA, cnt_q[7:0]};

    always_comb begin
        state_d     = state_q;
        is_prog_d   = is_prog_q;
        cnt_d       = cnt_q;
        widx_d      = widx_q;
        byte_d      = byte_q;
        word_d      = word_q;
        err_d       = err_q;
        prog_addr_d = prog_addr_q;
        prog_data_d = prog_data_q;
        data_addr_d = data_addr_q;
        data_data_d = data_data_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        chk_d       = chk_q;
`endif
        if (EN) begin
            case (state_q)
                IDLE: if (acc) begin
                    byte_d = 2'd0;
                    widx_d = 16'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    chk_d  = 8'd0;
`endif
                    if (IN_DATA == TAG_P || IN_DATA == TAG_D) begin
                        is_prog_d = IN_DATA == TAG_P;
                        state_d   = CNT_LO;
                    end else if (IN_DATA == TAG_G) begin
                        state_d = DONE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CNT_LO: if (acc) begin
                    cnt_d   = {cnt_q[15:8], IN_DATA};
                    state_d = CNT_HI;
                end
                CNT_HI: if (acc) begin
                    cnt_d = n;
                    if (n == 16'd0) begin
                        state_d = END_ST;
                    end else if ({1'b0, n} > 17'(MAX_WORDS)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
                PAYLOAD: if (acc) begin
                    // little-endian: shifting right leaves the first byte in the low lane
                    word_d = {IN_DATA, word_q[DATA_W-1:8]};
                    byte_d = byte_q + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    chk_d  = chk_q ^ IN_DATA;
`endif
                    if (byte_q == 2'd3) begin
                        state_d = WRITE;
                        if (is_prog_q) begin
                            prog_addr_d = widx_q[ADDR_W-1:0];
                            prog_data_d = word_d;
                        end else begin
                            data_addr_d = widx_q[ADDR_W-1:0];
                            data_data_d = word_d;
                        end
                    end
                end
                WRITE: begin
                    widx_d  = widx_q + 16'd1;
                    state_d = (widx_d == cnt_q) ? END_ST : PAYLOAD;
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                CHECK: if (acc) begin
                    err_d   = err_q | (IN_DATA != chk_q);
                    state_d = IDLE;
                end
`endif
                DONE: state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= IDLE;
            is_prog_q   <= 1'b0;
            cnt_q       <= '0;
            widx_q      <= '0;
            byte_q      <= '0;
            word_q      <= '0;
            err_q       <= 1'b0;
            rdy_q       <= 1'b0;
            prog_addr_q <= '0;
            prog_data_q <= '0;
            data_addr_q <= '0;
            data_data_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            is_prog_q   <= is_prog_d;
            cnt_q       <= cnt_d;
            widx_q      <= widx_d;
            byte_q      <= byte_d;
            word_q      <= word_d;
            err_q       <= err_d;
            rdy_q       <= 1'b1;
            prog_addr_q <= prog_addr_d;
            prog_data_q <= prog_data_d;
            data_addr_q <= data_addr_d;
            data_data_q <= data_data_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_q       <= chk_d;
`endif
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed vector table plus hand-written frame sequences for prog_loader.
module tb_prog_loader;
    logic        CLK = 1'b0, RSTn = 1'b1, EN = 1'b1, IN_VALID = 1'b0;
    logic [7:0]  IN_DATA = 8'h00;
    logic        IN_READY, PROG_CTRL, DATA_CTRL, START, BUSY, ERR;
    logic [9:0]  PROG_ADDR, DATA_ADDR;
    logic [31:0] PROG_DATA, DATA_DATA;
    int          n_cmp = 0, n_bad = 0;
    logic [41:0] pq[$], dq[$];

    typedef struct {
        bit en, vld; logic [7:0] din;
        bit rdy, dctl, busy, start, err; logic [31:0] ddata;
    } vec_t;
    vec_t vecs[$];

    prog_loader dut (.CLK(CLK), .RSTn(RSTn), .EN(EN), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
        .IN_READY(IN_READY), .PROG_CTRL(PROG_CTRL), .PROG_ADDR(PROG_ADDR), .PROG_DATA(PROG_DATA),
        .DATA_CTRL(DATA_CTRL), .DATA_ADDR(DATA_ADDR), .DATA_DATA(DATA_DATA),
        .START(START), .BUSY(BUSY), .ERR(ERR));

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (PROG_CTRL) pq.push_back({PROG_ADDR, PROG_DATA});
        if (DATA_CTRL) dq.push_back({DATA_ADDR, DATA_DATA});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input bit en, input bit vld, input logic [7:0] din, input bit rdy, input bit dctl,
                       input bit busy, input bit start, input logic [31:0] ddata);
        vec_t v;
        v.en = en; v.vld = vld; v.din = din; v.rdy = rdy; v.dctl = dctl;
        v.busy = busy; v.start = start; v.err = 1'b0; v.ddata = ddata;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RSTn = 1'b0; EN = 1'b1; IN_VALID = 1'b0; IN_DATA = 8'h00;
        #2;
        chk("rst_ctrl", {30'd0, PROG_CTRL, DATA_CTRL}, 32'd0);
        chk("rst_paddr_daddr", {12'd0, PROG_ADDR, DATA_ADDR}, 32'd0);
        chk("rst_pdata", PROG_DATA, 32'd0);
        chk("rst_ddata", DATA_DATA, 32'd0);
        chk("rst_flags", {28'd0, START, BUSY, ERR, IN_READY}, 32'd0);
        @(posedge CLK); #1;
        RSTn = 1'b1;
        #1 chk("rst_ready_release", {31'd0, IN_READY}, 32'd0);
        @(posedge CLK); #1;
        chk("rst_ready_after", {31'd0, IN_READY}, 32'd1);
        pq.delete(); dq.delete();
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        int t = 0;
        if (gap) begin
            int g = $urandom_range(0, 2);
            repeat (g) begin @(posedge CLK); #1; end
        end
        IN_DATA = b; IN_VALID = 1'b1;
        while (!IN_READY && t < 50) begin @(posedge CLK); #1; t++; end
        if (t >= 50) chk("ready_timeout", {31'd0, IN_READY}, 32'd1);
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] tag, input int n, input logic [31:0] w0,
                              input logic [31:0] w1, input bit gap);
        logic [7:0] cs = 8'h00;
        logic [31:0] w;
        logic [15:0] nn = 16'(n);
        send(tag, gap); send(nn[7:0], gap); send(nn[15:8], gap);
        for (int i = 0; i < n; i++) begin
            w = (i == 0) ? w0 : w1;
            for (int k = 0; k < 4; k++) begin
                send(w[8*k +: 8], gap);
                cs ^= w[8*k +: 8];
            end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        send(cs, gap);
`endif
        repeat (2) @(posedge CLK); #1;
    endtask

    task automatic check_q(input string name, input bit prog, input int n,
                           input logic [41:0] e0, input logic [41:0] e1);
        int sz = prog ? pq.size() : dq.size();
        chk({name, "_count"}, 32'(sz), 32'(n));
        for (int i = 0; i < n && i < sz; i++)
            chk($sformatf("%s_w%0d", name, i), 32'(prog ? pq[i] : dq[i]), 32'(i == 0 ? e0 : e1));
        for (int i = 0; i < n && i < sz; i++)
            chk($sformatf("%s_a%0d", name, i), 32'((prog ? pq[i] : dq[i]) >> 32), 32'((i == 0 ? e0 : e1) >> 32));
    endtask

    initial begin
        // D frame then G as cycle-by-cycle vectors; each row's outputs are observed before its clock edge
        add(1, 1, 8'h44, 1, 0, 0, 0, 32'h0);
        add(1, 1, 8'h01, 1, 0, 1, 0, 32'h0);
        add(1, 1, 8'h00, 1, 0, 1, 0, 32'h0);
        add(1, 1, 8'hEF, 1, 0, 1, 0, 32'h0);
        add(1, 1, 8'hBE, 1, 0, 1, 0, 32'h0);
        add(1, 1, 8'hAD, 1, 0, 1, 0, 32'h0);
        add(1, 1, 8'hDE, 1, 0, 1, 0, 32'h0);
        add(0, 0, 8'h00, 0, 0, 1, 0, 32'hDEADBEEF);
        add(1, 0, 8'h00, 0, 1, 1, 0, 32'hDEADBEEF);
`ifdef PROG_LOADER_CHECKSUM_EN
        add(1, 1, 8'h22, 1, 0, 1, 0, 32'hDEADBEEF);
`endif
        add(1, 1, 8'h47, 1, 0, 0, 0, 32'hDEADBEEF);
        add(1, 1, 8'h50, 0, 0, 1, 1, 32'hDEADBEEF);
        add(0, 1, 8'h50, 0, 0, 1, 1, 32'hDEADBEEF);
        add(1, 0, 8'h00, 0, 0, 1, 1, 32'hDEADBEEF);

        do_reset();
        foreach (vecs[i]) begin
            EN = vecs[i].en; IN_VALID = vecs[i].vld; IN_DATA = vecs[i].din;
            #1;
            chk($sformatf("vec%0d_ready", i), {31'd0, IN_READY}, {31'd0, vecs[i].rdy});
            chk($sformatf("vec%0d_dctl", i), {31'd0, DATA_CTRL}, {31'd0, vecs[i].dctl});
            chk($sformatf("vec%0d_pctl", i), {31'd0, PROG_CTRL}, 32'd0);
            chk($sformatf("vec%0d_busy", i), {31'd0, BUSY}, {31'd0, vecs[i].busy});
            chk($sformatf("vec%0d_start", i), {31'd0, START}, {31'd0, vecs[i].start});
            chk($sformatf("vec%0d_err", i), {31'd0, ERR}, {31'd0, vecs[i].err});
            chk($sformatf("vec%0d_daddr", i), {22'd0, DATA_ADDR}, 32'd0);
            chk($sformatf("vec%0d_ddata", i), DATA_DATA, vecs[i].ddata);
            @(posedge CLK); #1;
        end
        EN = 1'b1; IN_VALID = 1'b0;
        check_q("dg_dwrites", 1'b0, 1, {10'd0, 32'hDEADBEEF}, 42'd0);

        do_reset();
        send_frame(8'h50, 2, 32'h00000013, 32'h00500093, 1'b0);
        check_q("p2_pwrites", 1'b1, 2, {10'd0, 32'h00000013}, {10'd1, 32'h00500093});
        chk("p2_no_dwrites", 32'(dq.size()), 32'd0);
        chk("p2_hold_addr", {22'd0, PROG_ADDR}, 32'd1);
        chk("p2_hold_data", PROG_DATA, 32'h00500093);
        chk("p2_idle", {30'd0, BUSY, ERR}, 32'd0);

        do_reset();
        send(8'h7A, 1'b0);
        chk("badtag_err", {30'd0, ERR, BUSY}, 32'd2);
        send_frame(8'h50, 1, 32'h11223344, 32'h0, 1'b0);
        check_q("badtag_pwrites", 1'b1, 1, {10'd0, 32'h11223344}, 42'd0);
        chk("badtag_err_sticky", {31'd0, ERR}, 32'd1);

        do_reset();
        send(8'h50, 1'b0); send(8'h01, 1'b0); send(8'h04, 1'b0);
        chk("big_busy", {31'd0, BUSY}, 32'd0);
        chk("big_err", {31'd0, ERR}, 32'd1);
        repeat (3) @(posedge CLK); #1;
        chk("big_no_writes", 32'(pq.size() + dq.size()), 32'd0);

        do_reset();
        send_frame(8'h50, 0, 32'h0, 32'h0, 1'b0);
        chk("n0_no_writes", 32'(pq.size() + dq.size()), 32'd0);
        chk("n0_idle_ok", {30'd0, BUSY, ERR}, 32'd0);

        do_reset();
        send(8'h50, 1'b1); send(8'h02, 1'b1); send(8'h00, 1'b1);
        send(8'h13, 1'b1); send(8'h00, 1'b1);
        EN = 1'b0; IN_VALID = 1'b1; IN_DATA = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("en_lo%0d_ready", i), {31'd0, IN_READY}, 32'd0);
            chk($sformatf("en_lo%0d_busy", i), {31'd0, BUSY}, 32'd1);
            @(posedge CLK); #1;
        end
        EN = 1'b1; IN_VALID = 1'b0;
        send(8'h00, 1'b1); send(8'h00, 1'b1);
        send(8'h93, 1'b1); send(8'h00, 1'b1); send(8'h50, 1'b1); send(8'h00, 1'b1);
`ifdef PROG_LOADER_CHECKSUM_EN
        send(8'hD0, 1'b1);
`endif
        repeat (2) @(posedge CLK); #1;
        check_q("en_pwrites", 1'b1, 2, {10'd0, 32'h00000013}, {10'd1, 32'h00500093});
        chk("en_final", {30'd0, BUSY, ERR}, 32'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
        do_reset();
        send(8'h50, 1'b0); send(8'h01, 1'b0); send(8'h00, 1'b0);
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0); send(8'h04, 1'b0);
        chk("cs_good_err", {31'd0, ERR}, 32'd0);
        chk("cs_good_busy", {31'd0, BUSY}, 32'd0);
        do_reset();
        send(8'h50, 1'b0); send(8'h01, 1'b0); send(8'h00, 1'b0);
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0); send(8'h05, 1'b0);
        chk("cs_bad_err", {31'd0, ERR}, 32'd1);
        check_q("cs_bad_pwrites", 1'b1, 1, {10'd0, 32'h04030201}, 42'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
